// File: rtl/acc_drain_quant.sv
// Captures a COLS x T_ROWS accumulator tile and drains it one quantized row per transfer.
// Row 0 is valid the edge after capture; o_data/o_row_idx hold while i_ready is low.
module acc_drain_quant #(
  parameter int AC_BW  = 24,
  parameter int COLS   = 5,
  parameter int T_ROWS = 5,
  parameter int O_BW   = 8,
  parameter int SH_BW  = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_capture,
  input  logic [AC_BW*COLS*T_ROWS-1:0]  i_acc_kernel,
  input  logic [SH_BW-1:0]              i_shift,
  input  logic                          i_relu_en,
  input  logic                          i_clr_ovr,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [O_BW*COLS-1:0]          o_data,
  output logic [2:0]                    o_row_idx,
  output logic                          o_last,
  output logic                          o_busy,
  output logic                          o_overrun
);

  localparam int RW = AC_BW * COLS;
  localparam logic [2:0] LAST_ROW = 3'(T_ROWS - 1);
  localparam logic signed [AC_BW:0] SAT_MAX = (AC_BW+1)'((1 << (O_BW - 1)) - 1);
  localparam logic signed [AC_BW:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                        state_q, state_d;
  logic [AC_BW*COLS*T_ROWS-1:0]  shadow_q;
  logic [2:0]                    row_q, row_d;
  logic [SH_BW-1:0]              shift_q;
  logic                          relu_q;
  logic                          ovr_q;
  logic                          load, ovr_set, xfer, last_row;
  logic [RW-1:0]                 row_bits;
  logic [SH_BW-1:0]              sh_eff;

  assign last_row = (row_q == LAST_ROW);
  assign xfer     = (state_q == DRAIN) && i_ready;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    load    = 1'b0;
    ovr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_capture) begin
          load    = 1'b1;
          row_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer && last_row) begin
          // A capture landing on the final transfer reloads with no bubble.
          row_d = '0;
          if (i_capture) load = 1'b1;
          else           state_d = IDLE;
        end else begin
          if (xfer)      row_d   = row_q + 3'd1;
          if (i_capture) ovr_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      shadow_q <= '0;
      shift_q  <= '0;
      relu_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      if (load) begin
        shadow_q <= i_acc_kernel;
        shift_q  <= i_shift;
        relu_q   <= i_relu_en;
      end
      if (ovr_set)        ovr_q <= 1'b1;
      else if (i_clr_ovr) ovr_q <= 1'b0;
    end
  end

  // Round half toward +inf in AC_BW+1 bits, then saturate to O_BW.
  function automatic logic [O_BW-1:0] quant(input logic signed [AC_BW-1:0] x,
                                            input logic [SH_BW-1:0] sh,
                                            input logic relu);
    logic signed [AC_BW:0] xe, rnd, sum, y;
    xe  = (relu && x[AC_BW-1]) ? '0 : {x[AC_BW-1], x};
    rnd = '0;
    if (sh != '0) rnd = $signed((AC_BW+1)'(1) << (sh - 1'b1));
    sum = xe + rnd;
    y   = sum >>> sh;
    if (y > SAT_MAX)      return SAT_MAX[O_BW-1:0];
    else if (y < SAT_MIN) return SAT_MIN[O_BW-1:0];
    else                  return y[O_BW-1:0];
  endfunction

  assign row_bits = shadow_q[row_q*RW +: RW];
  assign sh_eff   = (shift_q > SH_BW'(AC_BW)) ? SH_BW'(AC_BW) : shift_q;

  always_comb begin
    o_data = '0;
    for (int k = 0; k < COLS; k++) begin
      o_data[k*O_BW +: O_BW] = quant(row_bits[k*AC_BW +: AC_BW], sh_eff, relu_q);
    end
  end

  assign o_valid   = (state_q == DRAIN);
  assign o_busy    = (state_q == DRAIN);
  assign o_last    = o_valid && last_row;
  assign o_row_idx = row_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_acc_drain_quant.sv
// Directed bench for acc_drain_quant: quantization, handshake, overrun and reset.
module tb_acc_drain_quant;
  localparam int AC_BW = 24, COLS = 5, T_ROWS = 5, O_BW = 8, SH_BW = 5;

  logic                          clk = 1'b0;
  logic                          rst_n;
  logic                          i_capture, i_relu_en, i_clr_ovr, i_ready;
  logic [AC_BW*COLS*T_ROWS-1:0]  i_acc_kernel;
  logic [SH_BW-1:0]              i_shift;
  logic                          o_valid, o_last, o_busy, o_overrun;
  logic [O_BW*COLS-1:0]          o_data;
  logic [2:0]                    o_row_idx;

  logic [AC_BW*COLS*T_ROWS-1:0]  acc;
  logic [15:0]                   pat;
  int                            n_vec = 0, n_err = 0, got;

  acc_drain_quant #(.AC_BW(AC_BW), .COLS(COLS), .T_ROWS(T_ROWS), .O_BW(O_BW), .SH_BW(SH_BW)) dut (
    .clk(clk), .rst_n(rst_n), .i_capture(i_capture), .i_acc_kernel(i_acc_kernel),
    .i_shift(i_shift), .i_relu_en(i_relu_en), .i_clr_ovr(i_clr_ovr), .i_ready(i_ready),
    .o_valid(o_valid), .o_data(o_data), .o_row_idx(o_row_idx), .o_last(o_last),
    .o_busy(o_busy), .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_el(input int r, input int k, input int v);
    acc[(r*COLS + k)*AC_BW +: AC_BW] = v[AC_BW-1:0];
  endtask

  // Element (r,k) = 4*(10r+k-20); with shift 2 it quantizes back to 10r+k-20.
  task automatic fill_ramp();
    for (int r = 0; r < T_ROWS; r++)
      for (int k = 0; k < COLS; k++)
        set_el(r, k, 4 * (r*10 + k - 20));
  endtask

  function automatic logic [O_BW*COLS-1:0] ramp_row(input int r);
    logic [O_BW*COLS-1:0] e;
    int v;
    e = '0;
    for (int k = 0; k < COLS; k++) begin
      v = r*10 + k - 20;
      e[k*O_BW +: O_BW] = v[O_BW-1:0];
    end
    return e;
  endfunction

  function automatic logic [7:0] el(input int k);
    return o_data[k*O_BW +: O_BW];
  endfunction

  task automatic cap(input int sh, input logic relu);
    i_acc_kernel = acc;
    i_shift      = sh[SH_BW-1:0];
    i_relu_en    = relu;
    i_capture    = 1'b1;
    tick();
    i_capture    = 1'b0;
    i_ready      = 1'b0;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    repeat (T_ROWS) tick();
    i_ready = 1'b0;
    chk("drain_idle", 64'(o_valid), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; i_capture = 1'b0; i_relu_en = 1'b0; i_clr_ovr = 1'b0;
    i_ready = 1'b0; i_acc_kernel = '0; i_shift = '0; acc = '0; pat = 16'hFB69;
    #2;
    chk("rst_valid",   64'(o_valid),   64'd0);
    chk("rst_data",    64'(o_data),    64'd0);
    chk("rst_row",     64'(o_row_idx), 64'd0);
    chk("rst_last",    64'(o_last),    64'd0);
    chk("rst_busy",    64'(o_busy),    64'd0);
    chk("rst_overrun", 64'(o_overrun), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Rounding with shift 4, then five back-to-back transfers.
    acc = '0;
    set_el(0, 0, 256); set_el(0, 1, 24); set_el(0, 2, -24);
    set_el(1, 0, -1000); set_el(1, 1, 40);
    cap(4, 1'b0);
    chk("cap_valid", 64'(o_valid), 64'd1);
    chk("cap_busy",  64'(o_busy),  64'd1);
    chk("r0k0_256",  64'(el(0)), 64'h10);
    chk("r0k1_24",   64'(el(1)), 64'h02);
    chk("r0k2_m24",  64'(el(2)), 64'hFF);
    i_ready = 1'b1;
    for (int i = 0; i < T_ROWS; i++) begin
      chk("xfer_valid", 64'(o_valid),   64'd1);
      chk("xfer_row",   64'(o_row_idx), 64'(i));
      chk("xfer_last",  64'(o_last),    64'(i == T_ROWS-1));
      if (i == 1) begin
        chk("r1k0_m1000", 64'(el(0)), 64'hC2);
        chk("r1k1_40",    64'(el(1)), 64'h03);
      end
      tick();
    end
    i_ready = 1'b0;
    chk("end_valid", 64'(o_valid), 64'd0);
    chk("end_busy",  64'(o_busy),  64'd0);

    // Saturation, ReLU and large shifts.
    acc = '0;
    set_el(0, 0, 32'h007FFFFF); set_el(0, 1, -8388608);
    cap(0, 1'b0);
    chk("sat_pos", 64'(el(0)), 64'h7F);
    chk("sat_neg", 64'(el(1)), 64'h80);
    drain();
    cap(0, 1'b1);
    chk("relu_pos", 64'(el(0)), 64'h7F);
    chk("relu_neg", 64'(el(1)), 64'h00);
    drain();
    cap(23, 1'b0);
    chk("sh23_pos", 64'(el(0)), 64'h01);
    chk("sh23_neg", 64'(el(1)), 64'hFF);
    drain();
    cap(31, 1'b0);
    chk("sh31_pos", 64'(el(0)), 64'h00);
    chk("sh31_neg", 64'(el(1)), 64'h00);
    drain();

    // Stalling ready pattern; shift/relu changes mid-drain must not matter.
    fill_ramp();
    cap(2, 1'b0);
    i_shift = '0; i_relu_en = 1'b1;
    got = 0;
    for (int j = 0; j < 16 && got < T_ROWS; j++) begin
      i_ready = pat[j];
      #1;
      chk("stall_valid", 64'(o_valid),   64'd1);
      chk("stall_row",   64'(o_row_idx), 64'(got));
      chk("stall_data",  64'(o_data),    64'(ramp_row(got)));
      tick();
      if (pat[j]) got++;
    end
    i_ready = 1'b0;
    chk("stall_count", 64'(got),     64'(T_ROWS));
    chk("stall_idle",  64'(o_valid), 64'd0);

    // Capture at row 2 is an overrun and leaves the shadow alone.
    cap(2, 1'b0);
    i_ready = 1'b1;
    tick(); tick();
    i_ready = 1'b0;
    i_acc_kernel = '0;
    i_capture = 1'b1;
    tick();
    i_capture = 1'b0;
    chk("ovr_set",  64'(o_overrun), 64'd1);
    chk("ovr_row2", 64'(o_row_idx), 64'd2);
    i_ready = 1'b1;
    for (int i = 2; i < T_ROWS; i++) begin
      chk("ovr_rest_row",  64'(o_row_idx), 64'(i));
      chk("ovr_rest_data", 64'(o_data),    64'(ramp_row(i)));
      tick();
    end
    i_ready = 1'b0;
    chk("ovr_idle",   64'(o_valid),   64'd0);
    chk("ovr_sticky", 64'(o_overrun), 64'd1);
    i_clr_ovr = 1'b1;
    tick();
    i_clr_ovr = 1'b0;
    chk("ovr_clr", 64'(o_overrun), 64'd0);

    // Capture coincident with the final transfer reloads without a bubble.
    cap(2, 1'b0);
    i_ready = 1'b1;
    repeat (4) tick();
    chk("co_row4", 64'(o_row_idx), 64'd4);
    chk("co_last", 64'(o_last),    64'd1);
    acc = '0;
    set_el(0, 0, 32'h007FFFFF); set_el(0, 1, -8388608);
    cap(0, 1'b0);
    chk("co_valid", 64'(o_valid),   64'd1);
    chk("co_row0",  64'(o_row_idx), 64'd0);
    chk("co_novr",  64'(o_overrun), 64'd0);
    chk("co_data",  64'(o_data),    64'h000000807F);

    // Overrun set wins over a same-cycle clear.
    i_capture = 1'b1; i_clr_ovr = 1'b1;
    tick();
    i_capture = 1'b0; i_clr_ovr = 1'b0;
    chk("setwin_ovr",  64'(o_overrun), 64'd1);
    chk("setwin_data", 64'(o_data),    64'h000000807F);

    // Asynchronous reset mid-drain at row 3.
    i_ready = 1'b1;
    repeat (3) tick();
    i_ready = 1'b0;
    chk("pre_rst_row", 64'(o_row_idx), 64'd3);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid",   64'(o_valid),   64'd0);
    chk("arst_data",    64'(o_data),    64'd0);
    chk("arst_row",     64'(o_row_idx), 64'd0);
    chk("arst_last",    64'(o_last),    64'd0);
    chk("arst_busy",    64'(o_busy),    64'd0);
    chk("arst_overrun", 64'(o_overrun), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
